fpu_scheduler: RTL and testbench

Issue controller for the single-precision FPU. Accepts one decoded FPU micro-op per cycle and resolves the dynamic rounding mode. Dispatches the op one-hot to FMA, DIV, SQRT, CMP, CVT or MISC. Guarantees at most one writeback per cycle: it reserves completion slots for the fixed-latency units and arbitrates the iterative DIV/SQRT results into free slots.

---
 rtl/fpu_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_fpu_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_scheduler.sv
// Issue controller for the single-precision FPU: resolves rounding, dispatches one-hot
// to the execution units and guarantees at most one writeback per cycle.
package fpu_pkg;
  typedef enum logic [2:0] {
    RM_RNE = 3'd0, RM_RTZ = 3'd1, RM_RDN = 3'd2, RM_RUP = 3'd3,
    RM_RMM = 3'd4, RM_NRD = 3'd5, RM_RSV = 3'd6, RM_DYN = 3'd7
  } fpu_rm_e;

  typedef logic [5:0] fpu_valid_t;

  localparam int U_FMA  = 0;
  localparam int U_DIV  = 1;
  localparam int U_SQRT = 2;
  localparam int U_CMP  = 3;
  localparam int U_CVT  = 4;
  localparam int U_MISC = 5;

  typedef struct packed {
    logic [4:0] op;
    fpu_rm_e    round_uop;
  } fpu_uop_t;
endpackage

module fpu_scheduler
  import fpu_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int FMA_LAT = 4,
  parameter int CVT_LAT = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  fpu_valid_t       issue_unit_i,
  input  fpu_uop_t         issue_uop_i,
  input  logic [TAG_W-1:0] issue_tag_i,
  input  logic [2:0]       frm_i,
  output fpu_valid_t       unit_valid_o,
  output fpu_uop_t         unit_uop_o,
  output logic             unit_kill_o,
  input  logic             div_done_i,
  input  logic             sqrt_done_i,
  output logic             div_ack_o,
  output logic             sqrt_ack_o,
  output logic             wb_valid_o,
  output fpu_valid_t       wb_sel_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] illegal_tag_o
);
  localparam int MAX_LAT = (FMA_LAT > CVT_LAT) ? FMA_LAT : CVT_LAT;

  typedef struct packed {
    logic             busy;
    fpu_valid_t       unit;
    logic [TAG_W-1:0] tag;
  } slot_t;

  slot_t            slot_q [MAX_LAT+1];
  slot_t            slot_d [MAX_LAT+1];
  slot_t            shifted [MAX_LAT+1];
  logic             div_busy_q, div_busy_d, sqrt_busy_q, sqrt_busy_d;
  logic [TAG_W-1:0] div_tag_q, div_tag_d, sqrt_tag_q, sqrt_tag_d;
  fpu_valid_t       unit_valid_q, unit_valid_d;
  fpu_uop_t         unit_uop_q, unit_uop_d;
  logic             kill_q, kill_d, illegal_q, illegal_d, run_q;
  logic [TAG_W-1:0] illegal_tag_q, illegal_tag_d;

  fpu_rm_e rm_res;
  logic    rounded, is_illegal, is_fixed, slot_hit, done_pending, stall;
  logic    accept, accept_ok;
  int      fix_lat;

  // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
  always_comb begin
    rm_res     = (issue_uop_i.round_uop == RM_DYN) ? fpu_rm_e'(frm_i) : issue_uop_i.round_uop;
    rounded    = issue_unit_i[U_FMA] | issue_unit_i[U_DIV] | issue_unit_i[U_SQRT] | issue_unit_i[U_CVT];
    is_illegal = !$onehot(issue_unit_i) || (rounded && (rm_res >= RM_NRD));
    is_fixed   = issue_unit_i[U_FMA] | issue_unit_i[U_CMP] | issue_unit_i[U_CVT] | issue_unit_i[U_MISC];
    fix_lat    = issue_unit_i[U_FMA] ? FMA_LAT : (issue_unit_i[U_CVT] ? CVT_LAT : 1);
  end

  // Table as it will look after this edge's shift; a booking lands at index = latency.
  always_comb begin
    shifted[MAX_LAT] = '0;
    for (int i = 0; i < MAX_LAT; i++) shifted[i] = slot_q[i+1];
    slot_hit = 1'b0;
    for (int i = 0; i <= MAX_LAT; i++) begin
      if (i == fix_lat) slot_hit = shifted[i].busy;
    end
  end

  // Iterative results fill cycles where no fixed slot drains; flush acks and discards them.
  always_comb begin
    div_ack_o    = div_done_i & div_busy_q & (flush_i | ~slot_q[0].busy);
    sqrt_ack_o   = sqrt_done_i & sqrt_busy_q & (flush_i | (~slot_q[0].busy & ~div_ack_o));
    done_pending = (div_done_i & div_busy_q & ~div_ack_o) | (sqrt_done_i & sqrt_busy_q & ~sqrt_ack_o);
    stall        = (issue_unit_i[U_DIV] & div_busy_q) | (issue_unit_i[U_SQRT] & sqrt_busy_q) |
                   (is_fixed & (slot_hit | done_pending));
    issue_ready_o = run_q & ~flush_i & (is_illegal | ~stall);
    accept       = issue_valid_i & issue_ready_o;
    accept_ok    = accept & ~is_illegal;
  end

  always_comb begin
    slot_d        = shifted;
    div_busy_d    = div_busy_q & ~div_ack_o;
    sqrt_busy_d   = sqrt_busy_q & ~sqrt_ack_o;
    div_tag_d     = div_tag_q;
    sqrt_tag_d    = sqrt_tag_q;
    unit_valid_d  = '0;
    unit_uop_d    = unit_uop_q;
    kill_d        = flush_i;
    illegal_d     = accept & is_illegal;
    illegal_tag_d = (accept & is_illegal) ? issue_tag_i : illegal_tag_q;
    if (accept_ok) begin
      unit_valid_d         = issue_unit_i;
      unit_uop_d.op        = issue_uop_i.op;
      unit_uop_d.round_uop = rounded ? rm_res : issue_uop_i.round_uop;
      if (is_fixed) begin
        for (int i = 0; i <= MAX_LAT; i++) begin
          if (i == fix_lat) slot_d[i] = '{busy: 1'b1, unit: issue_unit_i, tag: issue_tag_i};
        end
      end
      if (issue_unit_i[U_DIV]) begin
        div_busy_d = 1'b1;
        div_tag_d  = issue_tag_i;
      end
      if (issue_unit_i[U_SQRT]) begin
        sqrt_busy_d = 1'b1;
        sqrt_tag_d  = issue_tag_i;
      end
    end
    if (flush_i) begin
      for (int i = 0; i <= MAX_LAT; i++) slot_d[i] = '0;
      div_busy_d  = 1'b0;
      sqrt_busy_d = 1'b0;
    end
  end

  // NOTE: state updates use '<=' so every flop samples pre-edge values. The reservation
  // table is built from flops rather than RAM, so it takes the async reset like any state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_q        <= '{default: '0};
      div_busy_q    <= 1'b0;
      sqrt_busy_q   <= 1'b0;
      div_tag_q     <= '0;
      sqrt_tag_q    <= '0;
      unit_valid_q  <= '0;
      unit_uop_q    <= '0;
      kill_q        <= 1'b0;
      illegal_q     <= 1'b0;
      illegal_tag_q <= '0;
      run_q         <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      div_busy_q    <= div_busy_d;
      sqrt_busy_q   <= sqrt_busy_d;
      div_tag_q     <= div_tag_d;
      sqrt_tag_q    <= sqrt_tag_d;
      unit_valid_q  <= unit_valid_d;
      unit_uop_q    <= unit_uop_d;
      kill_q        <= kill_d;
      illegal_q     <= illegal_d;
      illegal_tag_q <= illegal_tag_d;
      run_q         <= 1'b1;
    end
  end

  always_comb begin
    wb_valid_o = 1'b0;
    wb_sel_o   = '0;
    wb_tag_o   = '0;
    if (slot_q[0].busy) begin
      wb_valid_o = 1'b1;
      wb_sel_o   = slot_q[0].unit;
      wb_tag_o   = slot_q[0].tag;
    end else if (div_ack_o && !flush_i) begin
      wb_valid_o      = 1'b1;
      wb_sel_o[U_DIV] = 1'b1;
      wb_tag_o        = div_tag_q;
    end else if (sqrt_ack_o && !flush_i) begin
      wb_valid_o       = 1'b1;
      wb_sel_o[U_SQRT] = 1'b1;
      wb_tag_o         = sqrt_tag_q;
    end
  end

  assign unit_valid_o  = unit_valid_q;
  assign unit_uop_o    = unit_uop_q;
  assign unit_kill_o   = kill_q;
  assign illegal_o     = illegal_q;
  assign illegal_tag_o = illegal_tag_q;
endmodule

// File: tb/tb_fpu_scheduler.sv
// Scoreboard bench for fpu_scheduler: a cycle-indexed reference model books expected
// dispatches, writebacks and acks; a negedge monitor compares them against the DUT.
module tb_fpu_scheduler;
  import fpu_pkg::*;

  localparam int TAG_W   = 4;
  localparam int FMA_LAT = 4;
  localparam int CVT_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush_i = 1'b0, issue_valid_i = 1'b0, issue_ready_o;
  fpu_valid_t       issue_unit_i = '0;
  fpu_uop_t         issue_uop_i = '0;
  logic [TAG_W-1:0] issue_tag_i = '0;
  logic [2:0]       frm_i = '0;
  fpu_valid_t       unit_valid_o, wb_sel_o;
  fpu_uop_t         unit_uop_o;
  logic             unit_kill_o, div_ack_o, sqrt_ack_o, wb_valid_o, illegal_o;
  logic             div_done_i = 1'b0, sqrt_done_i = 1'b0;
  logic [TAG_W-1:0] wb_tag_o, illegal_tag_o;

  fpu_scheduler #(.TAG_W(TAG_W), .FMA_LAT(FMA_LAT), .CVT_LAT(CVT_LAT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_unit_i(issue_unit_i), .issue_uop_i(issue_uop_i), .issue_tag_i(issue_tag_i),
    .frm_i(frm_i), .unit_valid_o(unit_valid_o), .unit_uop_o(unit_uop_o),
    .unit_kill_o(unit_kill_o), .div_done_i(div_done_i), .sqrt_done_i(sqrt_done_i),
    .div_ack_o(div_ack_o), .sqrt_ack_o(sqrt_ack_o), .wb_valid_o(wb_valid_o),
    .wb_sel_o(wb_sel_o), .wb_tag_o(wb_tag_o), .illegal_o(illegal_o),
    .illegal_tag_o(illegal_tag_o)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; fpu_valid_t unit; fpu_uop_t uop; } disp_t;
  typedef struct { int cyc; logic [TAG_W-1:0] tag; } ill_t;
  typedef struct { int cyc; fpu_valid_t sel; logic [TAG_W-1:0] tag; } wb_t;
  typedef struct { int cyc; logic chk_rdy; logic rdy; logic dack; logic sack; logic kill; } ctl_t;

  disp_t disp_q[$];
  ill_t  ill_q[$];
  wb_t   wb_q[$];
  ctl_t  ctl_q[$];
  wb_t   book[int];

  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  logic mon_en = 1'b0;
  logic m_div_busy = 1'b0, m_sqrt_busy = 1'b0, m_kill_next = 1'b0;
  int   m_div_at = 0, m_sqrt_at = 0, div_delay = 4, sqrt_delay = 4;
  logic [TAG_W-1:0] m_div_tag = '0, m_sqrt_tag = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic fpu_valid_t bit_of(input int u);
    fpu_valid_t v;
    v = '0;
    v[u] = 1'b1;
    return v;
  endfunction

  // One clock of stimulus; the model applies the scheduling rules in absolute cycles.
  task automatic step(input logic v, input fpu_valid_t u, input logic [4:0] op, input fpu_rm_e rm,
                      input logic [TAG_W-1:0] tag, input logic [2:0] frm, input logic fl);
    int l;
    logic onehot, rounded, illegal, fixed, ddone, sdone, dack, sack, pend, rdy, drain;
    fpu_rm_e  res;
    fpu_uop_t exp_uop;
    @(posedge clk);
    cyc++;
    #1;
    ddone = m_div_busy && (cyc >= m_div_at);
    sdone = m_sqrt_busy && (cyc >= m_sqrt_at);
    issue_valid_i = v; issue_unit_i = u; issue_tag_i = tag; frm_i = frm; flush_i = fl;
    issue_uop_i   = '{op: op, round_uop: rm};
    div_done_i = ddone; sqrt_done_i = sdone;
    onehot  = ($countones(u) == 1);
    rounded = onehot && (u[U_FMA] || u[U_DIV] || u[U_SQRT] || u[U_CVT]);
    res     = (rm == RM_DYN) ? fpu_rm_e'(frm) : rm;
    illegal = !onehot || (rounded && (int'(res) >= 5));
    fixed   = onehot && !u[U_DIV] && !u[U_SQRT];
    l       = u[U_FMA] ? FMA_LAT : (u[U_CVT] ? CVT_LAT : 1);
    drain   = book.exists(cyc);
    dack    = ddone && (fl || !drain);
    sack    = sdone && (fl || (!drain && !dack));
    pend    = (ddone && !dack) || (sdone && !sack);
    rdy     = !fl && (illegal || !((u[U_DIV] && m_div_busy) || (u[U_SQRT] && m_sqrt_busy) ||
                                   (fixed && (book.exists(cyc + 1 + l) || pend))));
    ctl_q.push_back('{cyc: cyc, chk_rdy: v, rdy: rdy, dack: dack, sack: sack, kill: m_kill_next});
    m_kill_next = fl;
    if (drain) wb_q.push_back(book[cyc]);
    else if (!fl && dack) wb_q.push_back('{cyc: cyc, sel: bit_of(U_DIV), tag: m_div_tag});
    else if (!fl && sack) wb_q.push_back('{cyc: cyc, sel: bit_of(U_SQRT), tag: m_sqrt_tag});
    if (drain) book.delete(cyc);
    if (dack) m_div_busy = 1'b0;
    if (sack) m_sqrt_busy = 1'b0;
    if (fl) begin
      book.delete();
      m_div_busy = 1'b0;
      m_sqrt_busy = 1'b0;
    end
    if (v && rdy) begin
      if (illegal) ill_q.push_back('{cyc: cyc + 1, tag: tag});
      else begin
        exp_uop = '{op: op, round_uop: (rounded ? res : rm)};
        disp_q.push_back('{cyc: cyc + 1, unit: u, uop: exp_uop});
        if (fixed) book[cyc + 1 + l] = '{cyc: cyc + 1 + l, sel: u, tag: tag};
        else if (u[U_DIV]) begin
          m_div_busy = 1'b1; m_div_tag = tag; m_div_at = cyc + div_delay;
        end else begin
          m_sqrt_busy = 1'b1; m_sqrt_tag = tag; m_sqrt_at = cyc + sqrt_delay;
        end
      end
    end
  endtask

  task automatic issue(input int unit, input logic [4:0] op, input fpu_rm_e rm,
                       input logic [TAG_W-1:0] tag, input logic [2:0] frm);
    step(1'b1, bit_of(unit), op, rm, tag, frm, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 5'd0, RM_RNE, '0, 3'd0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(issue_ready_o), 32'd0);
    check({tag, "_unit_valid"}, 32'(unit_valid_o), 32'd0);
    check({tag, "_unit_uop"}, 32'({unit_uop_o}), 32'd0);
    check({tag, "_kill"}, 32'(unit_kill_o), 32'd0);
    check({tag, "_wb"}, 32'({wb_valid_o, wb_sel_o, wb_tag_o}), 32'd0);
    check({tag, "_acks"}, 32'({div_ack_o, sqrt_ack_o}), 32'd0);
    check({tag, "_illegal"}, 32'({illegal_o, illegal_tag_o}), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    issue_valid_i = 1'b0; flush_i = 1'b0; div_done_i = 1'b0; sqrt_done_i = 1'b0;
    issue_unit_i = '0;
    #1;
    check_reset_outputs("midrun_reset");
    disp_q.delete(); ill_q.delete(); wb_q.delete(); ctl_q.delete(); book.delete();
    m_div_busy = 1'b0; m_sqrt_busy = 1'b0; m_kill_next = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en && ctl_q.size() != 0) begin
      ctl_t c;
      logic exp;
      c = ctl_q.pop_front();
      if (c.chk_rdy) check("issue_ready", 32'(issue_ready_o), 32'(c.rdy));
      check("div_ack", 32'(div_ack_o), 32'(c.dack));
      check("sqrt_ack", 32'(sqrt_ack_o), 32'(c.sack));
      check("unit_kill", 32'(unit_kill_o), 32'(c.kill));
      exp = (disp_q.size() != 0) && (disp_q[0].cyc == c.cyc);
      check("unit_valid", 32'(unit_valid_o), exp ? 32'(disp_q[0].unit) : 32'd0);
      if (exp) begin
        check("unit_uop", 32'({unit_uop_o}), 32'({disp_q[0].uop}));
        void'(disp_q.pop_front());
      end
      exp = (ill_q.size() != 0) && (ill_q[0].cyc == c.cyc);
      check("illegal", 32'(illegal_o), 32'(exp));
      if (exp) begin
        check("illegal_tag", 32'(illegal_tag_o), 32'(ill_q[0].tag));
        void'(ill_q.pop_front());
      end
      exp = (wb_q.size() != 0) && (wb_q[0].cyc == c.cyc);
      check("wb_valid", 32'(wb_valid_o), 32'(exp));
      check("wb_sel", 32'(wb_sel_o), exp ? 32'(wb_q[0].sel) : 32'd0);
      if (exp) begin
        check("wb_tag", 32'(wb_tag_o), 32'(wb_q[0].tag));
        void'(wb_q.pop_front());
      end
    end
  end

  initial begin
    int drain_cycles;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    mon_en = 1'b1;

    // FMA tag 3 writes back 1+FMA_LAT after accept
    issue(U_FMA, 5'd1, RM_RNE, 4'd3, 3'd0);
    idle(6);
    // FMA then CMP landing on the same slot: CMP stalls one cycle
    issue(U_FMA, 5'd2, RM_RUP, 4'd1, 3'd0);
    idle(2);
    issue(U_CMP, 5'd3, RM_DYN, 4'd2, 3'd0);
    issue(U_CMP, 5'd3, RM_DYN, 4'd2, 3'd0);
    idle(4);
    // DIV busy blocks a second DIV; its done collides with an FMA drain
    div_delay = 6;
    issue(U_DIV, 5'd4, RM_RDN, 4'd7, 3'd0);
    issue(U_FMA, 5'd5, RM_RNE, 4'd5, 3'd0);
    issue(U_DIV, 5'd4, RM_RNE, 4'd8, 3'd0);
    idle(8);
    // Dynamic rounding: legal RTZ, then illegal frm=7
    issue(U_CVT, 5'd6, RM_DYN, 4'd4, 3'b001);
    issue(U_CVT, 5'd6, RM_DYN, 4'd9, 3'b111);
    issue(U_MISC, 5'd7, RM_RSV, 4'd10, 3'b111);
    step(1'b1, 6'b000011, 5'd1, RM_RNE, 4'd11, 3'd0, 1'b0);
    idle(3);
    // Simultaneous DIV/SQRT done: DIV first, fixed issue stalled until both acked
    div_delay = 5;
    sqrt_delay = 4;
    issue(U_DIV, 5'd8, RM_RNE, 4'd1, 3'd0);
    issue(U_SQRT, 5'd9, RM_RNE, 4'd2, 3'd0);
    idle(3);
    for (int i = 0; i < 3; i++) issue(U_FMA, 5'd10, RM_RNE, 4'(12 + i), 3'd0);
    idle(8);
    // Flush with work in flight, then a fresh FMA
    sqrt_delay = 10;
    issue(U_FMA, 5'd1, RM_RNE, 4'd1, 3'd0);
    issue(U_FMA, 5'd1, RM_RNE, 4'd2, 3'd0);
    issue(U_SQRT, 5'd2, RM_RNE, 4'd3, 3'd0);
    step(1'b1, bit_of(U_FMA), 5'd1, RM_RNE, 4'd6, 3'd0, 1'b1);
    issue(U_FMA, 5'd1, RM_RNE, 4'd4, 3'd0);
    idle(8);

    for (int n = 0; n < 3000; n++) begin
      fpu_valid_t u;
      fpu_rm_e    rm;
      logic [2:0] frm;
      if (n == 1500) do_reset();
      u = ($urandom_range(0, 9) == 0) ? fpu_valid_t'($urandom_range(0, 63))
                                      : bit_of($urandom_range(0, 5));
      rm  = ($urandom_range(0, 2) == 0) ? RM_DYN : fpu_rm_e'($urandom_range(0, 7));
      frm = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      div_delay  = 2 + $urandom_range(0, 8);
      sqrt_delay = 2 + $urandom_range(0, 8);
      step($urandom_range(0, 3) != 0, u, 5'($urandom_range(0, 31)), rm,
           4'($urandom_range(0, 15)), frm, $urandom_range(0, 49) == 0);
    end

    drain_cycles = 0;
    while ((book.size() != 0 || m_div_busy || m_sqrt_busy || disp_q.size() != 0 ||
            ill_q.size() != 0 || wb_q.size() != 0) && drain_cycles < 40) begin
      idle(1);
      drain_cycles++;
    end
    idle(1);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("drain_budget", 32'(drain_cycles < 40), 32'd1);
    check("pending_dispatch", 32'(disp_q.size()), 32'd0);
    check("pending_writeback", 32'(wb_q.size()), 32'd0);
    check("pending_illegal", 32'(ill_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
